rv32i_wb_arbiter: RTL and testbench

- Write-back side of the integer register file: merges the fixed-latency pipeline result stream and the variable-latency load/store-unit (LSU) result channel into the register file's single write port (we/waddr/wdata).
- Buffers LSU results in a small FIFO and publishes a per-register pending mask for hazard detection.
- Raises a stall request when buffered LSU results are being starved of the write port.

---
 rtl/rv32i_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_rv32i_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_wb_arbiter.sv
// Write-back arbiter for the integer register file: the pipeline result stream always
// wins the single write port, and LSU results queue in a small FIFO behind it.
module rv32i_wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] rd_pending,
  output logic        stall_req
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam logic [3:0]  SMAX = 4'(STARVE_MAX);

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       starve_q, starve_d;

  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic             stall_q, stall_d;

  logic claim, empty, full, push, pop, head_live, push_live;
  logic [31:0] pending;

  assign claim     = pipe_valid && (pipe_rd != '0);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign lsu_ready = !full;
  assign push      = lsu_valid && !full && (lsu_rd != '0);
  assign head_live = !empty && live_q[head_q];
  // A squashed head needs no port, so it drains even while the pipeline is writing.
  assign pop       = !empty && (!live_q[head_q] || !claim);
  // LSU results are older than a concurrent pipeline write to the same register.
  assign push_live = !(claim && (lsu_rd == pipe_rd));

  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (claim && live_q[i] && (ent_rd_q[i] == pipe_rd)) begin
        live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[head_q] = 1'b0;
    end
    if (push) begin
      live_d[tail_q] = push_live;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (head_live && claim && (starve_q != SMAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign stall_d = (starve_d == SMAX);

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (claim) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end else if (pop && live_q[head_q]) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ent_rd_q[head_q];
      rf_wdata_d = ent_data_q[head_q];
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i]) begin
        pending[ent_rd_q[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      stall_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      live_q     <= live_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      stall_q    <= stall_d;
      if (pop) begin
        head_q <= head_q + AW'(1);
      end
      if (push) begin
        ent_rd_q[tail_q]   <= lsu_rd;
        ent_data_q[tail_q] <= lsu_data;
        tail_q             <= tail_q + AW'(1);
      end
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign stall_req  = stall_q;
  assign rd_pending = pending;

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Bench for rv32i_wb_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the write-back rules.
module tb_rv32i_wb_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rd_pending;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_pending(rd_pending), .stall_req(stall_req)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: FIFO as a queue of {live, rd, data}, head at index 0.
  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  int          m_cnt = 0;
  logic        m_stall = 1'b0;
  logic [31:0] dut_rf [32];

  initial begin
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
  end

  always @(posedge clk or negedge rst_n) begin : model
    bit   claim, hl, popping, acc;
    int   sz;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0; m_stall = 1'b0;
    end else begin
      claim   = pipe_valid && (pipe_rd != 5'd0);
      sz      = mq.size();
      hl      = (sz > 0) && mq[0].live;
      popping = (sz > 0) && (!mq[0].live || !claim);
      acc     = lsu_valid && (sz < int'(DEPTH));
      if (claim) begin
        m_we = 1'b1; m_waddr = pipe_rd; m_wdata = pipe_data;
      end else if (popping && hl) begin
        m_we = 1'b1; m_waddr = mq[0].rd; m_wdata = mq[0].data;
      end else begin
        m_we = 1'b0;
      end
      if (sz == 0 || popping) m_cnt = 0;
      else if (hl && claim && m_cnt < int'(STARVE_MAX)) m_cnt++;
      m_stall = (m_cnt == int'(STARVE_MAX));
      if (popping) void'(mq.pop_front());
      if (acc && lsu_rd != 5'd0) begin
        e.live = 1'b1; e.rd = lsu_rd; e.data = lsu_data;
        mq.push_back(e);
      end
      if (claim) begin
        foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] pend;
    pend = '0;
    foreach (mq[i]) if (mq[i].live) pend[mq[i].rd] = 1'b1;
    pend[0] = 1'b0;
    chk("cyc_rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("cyc_rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("cyc_rf_wdata", rf_wdata, m_wdata);
    chk("cyc_rd_pending", rd_pending, pend);
    chk("cyc_stall_req", {31'd0, stall_req}, {31'd0, m_stall});
    chk("cyc_lsu_ready", {31'd0, lsu_ready}, {31'd0, (mq.size() < int'(DEPTH))});
    if (rf_we) dut_rf[rf_waddr] = rf_wdata;
  end

  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk); #1;
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_pending", rd_pending, 32'd0);

    // Pipeline only
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(1);
    chk("t1_we", {31'd0, rf_we}, 32'd1);
    chk("t1_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t1_model_wdata", m_wdata, 32'hDEADBEEF);
    step(1'b1, 5'd0, 32'h1111, 1'b0, 5'd0, 32'd0);
    idle(1);
    chk("t1_rd0_we", {31'd0, rf_we}, 32'd0);

    // LSU minimum latency
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    idle(1);
    chk("t2_pending7", {31'd0, rd_pending[7]}, 32'd1);
    chk("t2_we_early", {31'd0, rf_we}, 32'd0);
    idle(1);
    chk("t2_we", {31'd0, rf_we}, 32'd1);
    chk("t2_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("t2_wdata", rf_wdata, 32'h1234);
    chk("t2_pending", rd_pending, 32'd0);
    idle(2);

    // Full FIFO back-pressure under continuous pipeline writes
    step(1'b1, 5'd20, 32'hA0, 1'b1, 5'd1, 32'h11);
    step(1'b1, 5'd20, 32'hA1, 1'b1, 5'd2, 32'h22);
    step(1'b1, 5'd20, 32'hA2, 1'b1, 5'd3, 32'h33);
    chk("t3_ready_full", {31'd0, lsu_ready}, 32'd0);
    step(1'b1, 5'd20, 32'hA3, 1'b1, 5'd3, 32'h33);
    step(1'b1, 5'd20, 32'hA4, 1'b1, 5'd3, 32'h33);
    chk("t3_ready_hold", {31'd0, lsu_ready}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    chk("t3_ready_b", {31'd0, lsu_ready}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    chk("t3_w1_we", {31'd0, rf_we}, 32'd1);
    chk("t3_w1_addr", {27'd0, rf_waddr}, 32'd1);
    chk("t3_w1_data", rf_wdata, 32'h11);
    chk("t3_ready_after", {31'd0, lsu_ready}, 32'd1);
    idle(1);
    chk("t3_w2_addr", {27'd0, rf_waddr}, 32'd2);
    chk("t3_w2_data", rf_wdata, 32'h22);
    idle(1);
    chk("t3_w3_addr", {27'd0, rf_waddr}, 32'd3);
    chk("t3_w3_data", rf_wdata, 32'h33);
    idle(3);
    chk("t3_x1", dut_rf[1], 32'h11);
    chk("t3_x2", dut_rf[2], 32'h22);

    // WAW squash
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h77);
    step(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'd0);
    chk("t4_pending_before", {31'd0, rd_pending[3]}, 32'd1);
    idle(1);
    chk("t4_pending_after", {31'd0, rd_pending[3]}, 32'd0);
    chk("t4_pipe_wdata", rf_wdata, 32'hAA);
    idle(1);
    chk("t4_squash_we", {31'd0, rf_we}, 32'd0);
    idle(2);
    chk("t4_x3", dut_rf[3], 32'hAA);

    // Starvation
    step(1'b1, 5'd4, 32'h40, 1'b1, 5'd9, 32'h99);
    for (int i = 1; i <= 4; i++) step(1'b1, 5'd4, 32'h40 + 32'(i), 1'b0, 5'd0, 32'd0);
    chk("t5_stall_early", {31'd0, stall_req}, 32'd0);
    step(1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'd0);
    chk("t5_stall", {31'd0, stall_req}, 32'd1);
    chk("t5_model_stall", {31'd0, m_stall}, 32'd1);
    idle(1);
    chk("t5_stall_held", {31'd0, stall_req}, 32'd1);
    idle(1);
    chk("t5_head_we", {31'd0, rf_we}, 32'd1);
    chk("t5_head_addr", {27'd0, rf_waddr}, 32'd9);
    chk("t5_head_data", rf_wdata, 32'h99);
    chk("t5_stall_clear", {31'd0, stall_req}, 32'd0);
    idle(2);

    // Reset mid-operation with two buffered entries
    step(1'b1, 5'd20, 32'hB0, 1'b1, 5'd11, 32'hB1);
    step(1'b1, 5'd20, 32'hB1, 1'b1, 5'd12, 32'hB2);
    step(1'b1, 5'd20, 32'hB2, 1'b0, 5'd0, 32'd0);
    chk("t6_full", {31'd0, lsu_ready}, 32'd0);
    chk("t6_pending11", {31'd0, rd_pending[11]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_we", {31'd0, rf_we}, 32'd0);
    chk("t6_rst_pending", rd_pending, 32'd0);
    chk("t6_rst_stall", {31'd0, stall_req}, 32'd0);
    pipe_valid = 1'b0; lsu_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("t6_ready", {31'd0, lsu_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t6_no_write", {31'd0, rf_we}, 32'd0);
    end
    chk("t6_x11", dut_rf[11], 32'd0);
    chk("t6_x12", dut_rf[12], 32'd0);

    // Random traffic with varying pipeline pressure
    for (int blk = 0; blk < 48; blk++) begin
      int unsigned ppct, lpct;
      ppct = $urandom_range(10, 95);
      lpct = $urandom_range(20, 90);
      for (int i = 0; i < 64; i++) begin
        step($urandom_range(0, 99) < ppct, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 99) < lpct, 5'($urandom_range(0, 7)), $urandom);
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
